fir_peak_detector: RTL
======================

Name: fir_peak_detector

Overview:
- Downstream stage of n_tap_fir (matched-filter output) in the pulse-compression chain.
- Consumes the signed FIR output stream and computes the absolute magnitude of each sample.
- Over a window of WINDOW_LENGTH accepted samples, finds the largest magnitude and its sample index, then reports both with a one-cycle strobe.
- Output feeds the range/target reporting logic.

Parameters:
- DATA_WIDTH, 19: width of signed dataIn; matches the FIR output width.
- WINDOW_LENGTH, 64: number of accepted samples per search window; must be 2 or more.
- INDEX_WIDTH, 6: width of peakIndex; 2^INDEX_WIDTH must be at least WINDOW_LENGTH.

Ports:
- clock, input, 1: system clock, rising edge.
- resetN, input, 1: asynchronous, active-low reset.
- startFlag, input, 1: begin a new search window (level sampled each clock).
- dataValid, input, 1: dataIn holds a valid FIR sample this cycle.
- dataIn, input, DATA_WIDTH signed: FIR output sample.
- busy, output, 1: high in SEARCH and DRAIN.
- peakValue, output, DATA_WIDTH unsigned: maximum magnitude found in the last completed window.
- peakIndex, output, INDEX_WIDTH: 0-based sample index of peakValue within the window.
- peakValid, output, 1: one-cycle strobe when peakValue/peakIndex update.

Behaviour:
- Reset (resetN=0, asynchronous): state=IDLE; busy, peakValid, peakValue, peakIndex all 0; internal counters, running max and pipeline registers cleared. Reset mid-window discards the window and produces no report.
- FSM states: IDLE, SEARCH, DRAIN, REPORT.
- IDLE:
  - dataValid is ignored.
  - startFlag=1 -> SEARCH; sampleCount=0, runMax=0, runIdx=0, stage-1 valid cleared.
- SEARCH, stage 1 (each edge with dataValid=1):
  - magReg <= |dataIn|, computed as DATA_WIDTH-bit unsigned. The most negative input -2^(DATA_WIDTH-1) maps to 2^(DATA_WIDTH-1) with no saturation.
  - idxReg <= sampleCount; s1Valid <= 1; sampleCount increments.
  - On an edge with dataValid=0, s1Valid <= 0.
- Stage 2 (every edge, including DRAIN): if s1Valid and magReg > runMax, then runMax <= magReg and runIdx <= idxReg.
  - The compare is strict: on a tie the earliest index wins.
  - An all-zero window reports value 0 at index 0.
- Window end: the edge that accepts sample number WINDOW_LENGTH-1 moves the FSM SEARCH -> DRAIN. Samples presented in DRAIN are ignored.
- DRAIN: lasts one cycle while stage 2 absorbs the final sample, then -> REPORT.
- REPORT: for one cycle, peakValue <= runMax, peakIndex <= runIdx, peakValid <= 1; then -> IDLE.
  - peakValid is therefore high during the cycle following the 2nd rising edge after the edge that accepted the final sample.
  - peakValid is low at all other times.
  - peakValue/peakIndex hold until the next report or reset.
- startFlag=1 during SEARCH or DRAIN: abort the current window without a report; clear and restart SEARCH on that edge. A sample presented on that same edge becomes index 0 of the new window.
- startFlag=1 while in REPORT: the report still completes; the FSM then goes to SEARCH instead of IDLE, with the same clear as from IDLE.
- Gaps in dataValid are allowed anywhere within SEARCH. Only accepted samples count toward the window and its indices.
- busy = (state==SEARCH) or (state==DRAIN), driven combinationally from the state register.
- Unused/unknown state encodings -> IDLE with all internals cleared.

Optional Feature:
- Macro: PEAK_THRESHOLD_EN.
- Defined:
  - Adds input threshold (DATA_WIDTH unsigned) and output peakDetected (1 bit, reset 0).
  - In REPORT, peakDetected <= (runMax >= threshold), registered together with peakValid and held like peakValue.
  - threshold is sampled in the REPORT cycle.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
1. Reset: assert resetN=0 mid-SEARCH, then release -> all outputs 0, state IDLE, no peakValid until a full new window completes.
2. WINDOW_LENGTH=8; start, then 8 back-to-back samples 3,-7,5,2,0,1,-1,4 -> peakValue=7, peakIndex=1, peakValid high exactly one cycle, 2 edges after the 8th sample.
3. Ties and gaps: samples 5,-5,2,5 with dataValid low for 3 cycles between each, then 4 more zeros -> peakValue=5, peakIndex=0, busy high throughout.
4. Extreme value: DATA_WIDTH=19, window containing -262144 at index 6 and 262143 at index 2 -> peakValue=262144, peakIndex=6.
5. Restart: startFlag pulsed after 5 samples of a window (max 100); the new window has max 9 at index 3 -> single report with peakValue=9, peakIndex=3, and no report for the aborted window. Also: startFlag held during REPORT -> report emitted and busy high on the next cycle.
6. PEAK_THRESHOLD_EN: threshold=50; a window with max 49 -> peakDetected=0; a window with max 50 -> peakDetected=1. Build without the macro -> ports absent and scenario 2 results unchanged.

Source files
------------

// File: rtl/fir_peak_detector.sv
// Magnitude peak search over a window of signed FIR samples; reports max |x| and its index.
// Optional build macro PEAK_THRESHOLD_EN adds a threshold input and a registered peakDetected flag.
`timescale 1ns/1ps
module fir_peak_detector #(
    parameter int unsigned DATA_WIDTH    = 19,
    parameter int unsigned WINDOW_LENGTH = 64,
    parameter int unsigned INDEX_WIDTH   = 6
) (
    input  logic                          clock,
    input  logic                          resetN,
    input  logic                          startFlag,
    input  logic                          dataValid,
    input  logic signed [DATA_WIDTH-1:0]  dataIn,
`ifdef PEAK_THRESHOLD_EN
    input  logic        [DATA_WIDTH-1:0]  threshold,
    output logic                          peakDetected,
`endif
    output logic                          busy,
    output logic        [DATA_WIDTH-1:0]  peakValue,
    output logic        [INDEX_WIDTH-1:0] peakIndex,
    output logic                          peakValid
);

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(WINDOW_LENGTH - 1);
    localparam logic [DATA_WIDTH-1:0]  ONE      = DATA_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    clear_c;
    logic                    accept_c;
    logic                    report_c;
    logic                    flush_c;

    logic [DATA_WIDTH-1:0]   data_u;
    logic [DATA_WIDTH-1:0]   mag_c;
    logic [DATA_WIDTH-1:0]   mag_reg;
    logic [INDEX_WIDTH-1:0]  idx_reg;
    logic                    s1_valid;
    logic [INDEX_WIDTH-1:0]  sample_count;
    logic [DATA_WIDTH-1:0]   run_max;
    logic [INDEX_WIDTH-1:0]  run_idx;

    // Two's-complement magnitude; the most negative input wraps to 2^(DATA_WIDTH-1) unsigned.
    assign data_u = dataIn;
    assign mag_c  = data_u[DATA_WIDTH-1] ? (~data_u + ONE) : data_u;

    assign busy = (state == ST_SEARCH) || (state == ST_DRAIN);

    // State register
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and datapath controls
    always_comb begin
        state_next = state;
        clear_c    = 1'b0;
        accept_c   = 1'b0;
        report_c   = 1'b0;
        flush_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (startFlag) begin
                    state_next = ST_SEARCH;
                    clear_c    = 1'b1;
                end
            end
            ST_SEARCH: begin
                accept_c = dataValid;
                if (startFlag) begin
                    clear_c = 1'b1;
                end else if (dataValid && (sample_count == LAST_IDX)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (startFlag) begin
                    state_next = ST_SEARCH;
                    clear_c    = 1'b1;
                    accept_c   = dataValid;
                end else begin
                    state_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                report_c   = 1'b1;
                clear_c    = startFlag;
                state_next = startFlag ? ST_SEARCH : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                flush_c    = 1'b1;
            end
        endcase
    end

    // Stage 1 (magnitude capture) and stage 2 (running maximum); a restart discards stage 2.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mag_reg      <= '0;
            idx_reg      <= '0;
            s1_valid     <= 1'b0;
            sample_count <= '0;
            run_max      <= '0;
            run_idx      <= '0;
        end else if (flush_c) begin
            mag_reg      <= '0;
            idx_reg      <= '0;
            s1_valid     <= 1'b0;
            sample_count <= '0;
            run_max      <= '0;
            run_idx      <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                mag_reg <= mag_c;
                idx_reg <= clear_c ? '0 : sample_count;
            end
            if (clear_c) begin
                sample_count <= INDEX_WIDTH'(accept_c);
                run_max      <= '0;
                run_idx      <= '0;
            end else begin
                if (accept_c) begin
                    sample_count <= sample_count + INDEX_WIDTH'(1);
                end
                if (s1_valid && (mag_reg > run_max)) begin
                    run_max <= mag_reg;
                    run_idx <= idx_reg;
                end
            end
        end
    end

    // Report registers: strobe every cycle, payload held between reports
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            peakValid <= 1'b0;
            peakValue <= '0;
            peakIndex <= '0;
        end else begin
            peakValid <= report_c;
            if (report_c) begin
                peakValue <= run_max;
                peakIndex <= run_idx;
            end
        end
    end

`ifdef PEAK_THRESHOLD_EN
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            peakDetected <= 1'b0;
        end else if (report_c) begin
            peakDetected <= (run_max >= threshold);
        end
    end
`else
    // No threshold comparison in this build.
`endif

endmodule
